// File: rtl/seq_pattern_gen_if.sv
// Control and pattern bus for seq_pattern_gen: the controller drives en/load/mode/seed,
// the generator returns the pattern, its strobes and its internal state for observation.
interface seq_pattern_gen_if #(
    parameter int WIDTH = 3
);
    // No valid/ready pair here: en and load are level-sampled on every rising edge,
    // step and wrap are single-cycle pulses that are valid on the same edge that q changes.
    logic             en;
    logic             load;
    logic [2:0]       mode;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] q;
    logic             step;
    logic             wrap;
    logic [2:0]       mode_state;
    logic [WIDTH:0]   idx_state;

    modport master (
        output en, load, mode, seed,
        input  q, step, wrap, mode_state, idx_state
    );

    modport slave (
        input  en, load, mode, seed,
        output q, step, wrap, mode_state, idx_state
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Prescaled multi-family pattern generator: binary up/down, Gray, Johnson, ring, LFSR,
// with load/seed, enable and step/wrap strobes.
module seq_pattern_gen #(
    parameter int               WIDTH     = 3,
    parameter int               PRESCALE  = 1,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(3'b110)
) (
    input  logic              clk,
    input  logic              rst,
    seq_pattern_gen_if.slave  bus
);
    localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW   = WIDTH + 1;

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

    localparam logic [2:0] MODE_BIN_UP   = 3'd0;
    localparam logic [2:0] MODE_BIN_DOWN = 3'd1;
    localparam logic [2:0] MODE_GRAY     = 3'd2;
    localparam logic [2:0] MODE_JOHNSON  = 3'd3;
    localparam logic [2:0] MODE_RING     = 3'd4;
    localparam logic [2:0] MODE_LFSR     = 3'd5;

    // Last index of each family's period; idx wraps to 0 after reaching it.
    localparam logic [IW-1:0] LAST_BIN     = IW'((1 << WIDTH) - 1);
    localparam logic [IW-1:0] LAST_JOHNSON = IW'(2 * WIDTH - 1);
    localparam logic [IW-1:0] LAST_RING    = IW'(WIDTH - 1);
    localparam logic [IW-1:0] LAST_LFSR    = IW'((1 << WIDTH) - 2);

    logic [2:0]       mode_r;
    logic [IW-1:0]    idx;
    logic [PC_W-1:0]  pc;
    logic [WIDTH-1:0] q_r;
    logic             step_r;
    logic             wrap_r;

    logic [IW-1:0]    idx_last;
    logic             at_last;
    logic [IW-1:0]    idx_nx;
    logic [WIDTH-1:0] idx_nx_w;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] start_q;

    always_comb begin
        idx_last = LAST_BIN;
        case (mode_r)
            MODE_JOHNSON: idx_last = LAST_JOHNSON;
            MODE_RING:    idx_last = LAST_RING;
            MODE_LFSR:    idx_last = LAST_LFSR;
            default:      idx_last = LAST_BIN;
        endcase
    end

    assign at_last  = (idx == idx_last);
    assign idx_nx   = at_last ? '0 : idx + IW'(1);
    assign idx_nx_w = idx_nx[WIDTH-1:0];

    // Counting families derive q from the next index; shift families derive it from q.
    always_comb begin
        q_nx = idx_nx_w;
        case (mode_r)
            MODE_BIN_DOWN: q_nx = ~idx_nx_w;
            MODE_GRAY:     q_nx = idx_nx_w ^ (idx_nx_w >> 1);
            MODE_JOHNSON:  q_nx = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
            MODE_RING:     q_nx = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            MODE_LFSR:     q_nx = {q_r[WIDTH-2:0], ^(q_r & LFSR_TAPS)};
            default:       q_nx = idx_nx_w;
        endcase
    end

    always_comb begin
        start_q = '0;
        case (bus.mode)
            MODE_BIN_DOWN: start_q = '1;
            MODE_RING:     start_q = WIDTH'(1);
            MODE_LFSR:     start_q = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
            default:       start_q = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= MODE_BIN_UP;
            idx    <= '0;
            pc     <= '0;
            q_r    <= '0;
            step_r <= 1'b0;
            wrap_r <= 1'b0;
        end else if (bus.load) begin
            mode_r <= bus.mode;
            idx    <= '0;
            pc     <= '0;
            q_r    <= start_q;
            step_r <= 1'b0;
            wrap_r <= 1'b0;
        end else if (bus.en) begin
            if (pc == PC_LAST) begin
                pc     <= '0;
                idx    <= idx_nx;
                q_r    <= q_nx;
                step_r <= 1'b1;
                wrap_r <= at_last;
            end else begin
                pc     <= pc + PC_W'(1);
                step_r <= 1'b0;
                wrap_r <= 1'b0;
            end
        end else begin
            step_r <= 1'b0;
            wrap_r <= 1'b0;
        end
    end

    assign bus.q          = q_r;
    assign bus.step       = step_r;
    assign bus.wrap       = wrap_r;
    assign bus.mode_state = mode_r;
    assign bus.idx_state  = idx;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (prescale 1 and 2) driven identically and
// compared every cycle against a sequence-level model, plus directed literal sequences.
module tb_seq_pattern_gen;
    localparam int W     = 3;
    localparam int MASK  = (1 << W) - 1;
    localparam int TAPS  = 6;

    logic clk;
    logic rst;

    seq_pattern_gen_if #(.WIDTH(W)) bus0 ();
    seq_pattern_gen_if #(.WIDTH(W)) bus1 ();

    seq_pattern_gen #(.WIDTH(W), .PRESCALE(1), .LFSR_TAPS(3'b110)) u0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    seq_pattern_gen #(.WIDTH(W), .PRESCALE(2), .LFSR_TAPS(3'b110)) u1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    bit  armed  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int mode;
        int idx;
        int pc;
        int q;
        bit step;
        bit wrap;
    } mstate_t;

    mstate_t m [2];
    int presc [2] = '{1, 2};

    function automatic int period(input int md);
        case (md)
            3:       return 2 * W;
            4:       return W;
            5:       return (1 << W) - 1;
            default: return 1 << W;
        endcase
    endfunction

    function automatic int start_val(input int md, input int sd);
        case (md)
            1:       return MASK;
            4:       return 1;
            5:       return (sd == 0) ? 1 : sd;
            default: return 0;
        endcase
    endfunction

    // Pattern value at sequence position k (LFSR is advanced from the previous value).
    function automatic int seq_at(input int md, input int k, input int qold);
        case (md)
            1: return MASK - k;
            2: return k ^ (k >> 1);
            3: return (k <= W) ? ((1 << k) - 1) : ((MASK << (k - W)) & MASK);
            4: return 1 << k;
            5: return ((qold << 1) & MASK) | ($countones(qold & TAPS) & 1);
            default: return k;
        endcase
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input int p, input bit en,
                                           input bit ld, input int md, input int sd);
        mstate_t n;
        n = s;
        n.step = 1'b0;
        n.wrap = 1'b0;
        if (ld) begin
            n.mode = md;
            n.idx  = 0;
            n.pc   = 0;
            n.q    = start_val(md, sd);
        end else if (en) begin
            if (s.pc < p - 1) begin
                n.pc = s.pc + 1;
            end else begin
                n.pc   = 0;
                n.step = 1'b1;
                n.wrap = (s.idx == period(s.mode) - 1);
                n.idx  = (s.idx + 1) % period(s.mode);
                n.q    = seq_at(s.mode, n.idx, s.q);
            end
        end
        return n;
    endfunction

    function automatic mstate_t model_reset();
        mstate_t r;
        r.mode = 0; r.idx = 0; r.pc = 0; r.q = 0; r.step = 1'b0; r.wrap = 1'b0;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m[0] <= model_reset();
            m[1] <= model_reset();
        end else begin
            m[0] <= model_next(m[0], presc[0], bus0.en, bus0.load, int'(bus0.mode), int'(bus0.seed));
            m[1] <= model_next(m[1], presc[1], bus1.en, bus1.load, int'(bus1.mode), int'(bus1.seed));
        end
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    always @(negedge clk) begin
        if (armed) begin
            chk("u0_q",    int'(bus0.q),    m[0].q);
            chk("u0_step", int'(bus0.step), int'(m[0].step));
            chk("u0_wrap", int'(bus0.wrap), int'(m[0].wrap));
            chk("u1_q",    int'(bus1.q),    m[1].q);
            chk("u1_step", int'(bus1.step), int'(m[1].step));
            chk("u1_wrap", int'(bus1.wrap), int'(m[1].wrap));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit en, input bit ld, input int md, input int sd);
        bus0.en = en;   bus1.en = en;
        bus0.load = ld; bus1.load = ld;
        bus0.mode = 3'(md); bus1.mode = 3'(md);
        bus0.seed = W'(sd); bus1.seed = W'(sd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mode(input int md, input int sd);
        drive(1'b1, 1'b1, md, sd);
        tick();
        drive(1'b1, 1'b0, md, sd);
    endtask

    // ---------------- directed + random stimulus ----------------
    int jseq [6] = '{1, 3, 7, 6, 4, 0};
    int rseq [3] = '{2, 4, 1};
    int lseq [7] = '{2, 5, 3, 7, 6, 4, 1};
    int gseq [4] = '{1, 3, 2, 6};

    initial begin
        int held;
        rst = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        #2 rst = 1'b1;
        #1 armed = 1'b1;
        chk("reset_q",    int'(bus0.q), 0);
        chk("reset_step", int'(bus0.step), 0);
        chk("reset_wrap", int'(bus0.wrap), 0);
        tick();
        rst = 1'b0;

        // binary up, prescale 1
        load_mode(0, 0);
        chk("binup_start", int'(bus0.q), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("binup_q",    int'(bus0.q), k % 8);
            chk("binup_step", int'(bus0.step), 1);
            chk("binup_wrap", int'(bus0.wrap), int'(k == 8));
        end

        // Johnson then ring
        load_mode(3, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("johnson_q",    int'(bus0.q), jseq[k]);
            chk("johnson_wrap", int'(bus0.wrap), int'(k == 5));
        end
        load_mode(4, 0);
        chk("ring_start", int'(bus0.q), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ring_q",    int'(bus0.q), rseq[k]);
            chk("ring_wrap", int'(bus0.wrap), int'(k == 2));
        end

        // LFSR with seed 1, then seed 0 substitutes 1
        load_mode(5, 1);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("lfsr_q",    int'(bus0.q), lseq[k]);
            chk("lfsr_wrap", int'(bus0.wrap), int'(k == 6));
        end
        load_mode(5, 0);
        chk("lfsr_seed0", int'(bus0.q), 1);

        // Gray on the prescale-2 instance, with an enable gap mid-phase
        load_mode(2, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("gray_hold_step", int'(bus1.step), 0);
            tick();
            chk("gray_q",    int'(bus1.q), gseq[k]);
            chk("gray_step", int'(bus1.step), 1);
        end
        tick();
        drive(1'b0, 1'b0, 2, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gap_q",    int'(bus1.q), 6);
            chk("gap_step", int'(bus1.step), 0);
        end
        drive(1'b1, 1'b0, 2, 0);
        tick();
        chk("resume_q",    int'(bus1.q), 7);
        chk("resume_step", int'(bus1.step), 1);

        // load while enabled at q=5 restarts with no strobes
        load_mode(0, 0);
        for (int k = 0; k < 5; k++) tick();
        chk("pre_load_q", int'(bus0.q), 5);
        drive(1'b1, 1'b1, 0, 0);
        tick();
        chk("midload_q",    int'(bus0.q), 0);
        chk("midload_step", int'(bus0.step), 0);
        chk("midload_wrap", int'(bus0.wrap), 0);

        // asynchronous reset between edges reverts mode to bin-up
        load_mode(3, 0);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_q",    int'(bus0.q), 0);
        chk("arst_step", int'(bus0.step), 0);
        chk("arst_wrap", int'(bus0.wrap), 0);
        chk("arst_mode", int'(bus0.mode_state), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_binup", int'(bus0.q), 1);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        drive(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Parametrised successor to the fixed 3-bit free-running sequence generator.
- Produces a WIDTH-bit output pattern that steps once every PRESCALE enabled clocks.
- Pattern families: binary up, binary down, Gray, Johnson, one-hot ring and maximal-length LFSR.
- Adds enable, load/seed with mode select, asynchronous reset, and step/wrap strobes so downstream blocks can track the sequence.

Parameters:
- WIDTH, 3: output width in bits; legal range 2..16.
- PRESCALE, 1: enabled clocks per sequence step; legal range 1..65535.
- LFSR_TAPS, 3'b110: Fibonacci feedback tap mask (WIDTH bits). Must be maximal-length for WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 freezes all state.
- load  input  1  synchronous reload: latch mode and seed, restart the sequence.
- mode  input  3  pattern select, sampled only when load=1: 0 bin-up, 1 bin-down, 2 Gray, 3 Johnson, 4 ring, 5 LFSR, 6/7 reserved (behave as bin-up).
- seed  input  WIDTH  LFSR start value, sampled only when load=1; ignored in other modes.
- q  output  WIDTH  registered pattern output.
- step  output  1  registered 1-cycle pulse; q changed on this edge.
- wrap  output  1  registered 1-cycle pulse; q returned to the start value on this edge.

Behaviour:
- Reset (rst=1, asynchronous): mode_r=0, idx=0, prescaler pc=0, q=0, step=0, wrap=0. Release is synchronous to clk; the first step can occur no earlier than PRESCALE enabled edges after release.
- Priority on each clk edge: rst > load > en.
- Load (load=1):
  - mode_r<=mode, idx<=0, pc<=0, step=0, wrap=0.
  - q<=start value: bin-up 0; bin-down all-ones; Gray 0; Johnson 0; ring 1; LFSR seed, or 1 if seed==0.
  - Load is honoured regardless of en.
- Enable and prescale: en=1 and pc<PRESCALE-1 -> pc<=pc+1, q held, step=0, wrap=0.
- Step: en=1 and pc==PRESCALE-1 -> pc<=0, q<=next(q), step=1. idx<=idx+1, or 0 if idx==PERIOD-1; in that case wrap=1 on the same edge.
- en=0: pc, idx and q hold; step=0, wrap=0. The prescale phase resumes where it stopped.
- PERIOD per mode: bin-up/down/Gray 2^WIDTH; Johnson 2*WIDTH; ring WIDTH; LFSR 2^WIDTH-1.
- next(q) per mode:
  - bin-up: q=idx mod 2^WIDTH.
  - bin-down: q=(2^WIDTH-1)-idx.
  - Gray: q=idx^(idx>>1).
  - Johnson: shift left, LSB <= ~q[MSB] (W=3: 000,001,011,111,110,100).
  - ring: rotate left (001,010,100).
  - LFSR: shift left, LSB <= XOR of q bits selected by LFSR_TAPS.
- Width rules: idx is WIDTH+1 bits wide. All arithmetic is modulo its width with no overflow beyond PERIOD. The pc width is sized for PRESCALE.
- wrap coincides with the step that restores the start value. There is no wrap on load or reset.
- Mid-sequence load restarts immediately; any pending prescale phase is discarded.
- A mode change takes effect only via load.
- Reset mid-step dominates with no partial update.

Test Plan:
- Reset then load mode=0, en=1, PRESCALE=1, WIDTH=3 -> q 0,1,...,7,0 on consecutive cycles; step every cycle; wrap=1 only on the 7->0 edge.
- Load mode=3 -> q 000,001,011,111,110,100,000; wrap on the 100->000 edge; period 6. Then load mode=4 -> 001,010,100,001; period 3.
- Load mode=5, seed=3'b001 -> 001,010,101,011,111,110,100,001; wrap after 7 steps. Repeat with seed=0 -> q starts at 001.
- PRESCALE=2, mode=2 -> q 000,001,011,010,110,... each held 2 cycles; step pulses every second edge. Toggle en low for 3 cycles mid-phase -> q, step and wrap frozen, and the phase resumes correctly.
- Assert load together with en while q=5 in bin-up -> next q=0 with step=0 and wrap=0. Assert rst asynchronously between edges -> q=0 and strobes=0 immediately, with mode reverting to bin-up.
